bip_uart_link: RTL and testbench

//  Control link between the uart block and the BIP processor. Receives a start command byte
//  (uart_to_bip/rx_done), resets and runs the BIP until it halts or times out, then sends a
//  7-byte result frame back through the uart transmitter (bip_to_uart/tx_start/tx_done).

---
 rtl/bip_link_pkg.sv | 41 ++++
 rtl/frame_sender.sv | 64 ++++++
 rtl/bip_uart_link.sv | 96 +++++++++
 tb/tb_bip_uart_link.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_link_pkg.sv
// Shared types and constants for the BIP <-> uart control link.
// A frame is status, accumulator, program counter and cycle count, sent high byte first.
package bip_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SEND,
        TX_WAIT
    } state_e;

    localparam logic [7:0] CMD_START_DEF  = 8'h53;
    localparam int         FRAME_LEN      = 7;
    localparam logic [2:0] LAST_IDX       = 3'(FRAME_LEN - 1);
    localparam logic [7:0] STATUS_HALT    = 8'h00;
    localparam logic [7:0] STATUS_TIMEOUT = 8'h01;

    typedef struct packed {
        logic [7:0]  status;
        logic [15:0] acc;
        logic [15:0] pc;
        logic [15:0] cyc;
    } frame_t;

    function automatic logic [7:0] frame_byte(input frame_t f, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = f.status;
            3'd1:    b = f.acc[15:8];
            3'd2:    b = f.acc[7:0];
            3'd3:    b = f.pc[15:8];
            3'd4:    b = f.pc[7:0];
            3'd5:    b = f.cyc[15:8];
            3'd6:    b = f.cyc[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/frame_sender.sv
// Holds a captured result frame and pushes it byte by byte through the uart transmitter.
// Handshake: start is a 1-cycle request accepted only in IDLE; done pulses on the edge the last tx_done is taken.
module frame_sender
    import bip_link_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  frame_t     frame_in,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       done,
    output state_e     state
);

    state_e     state_q;
    state_e     state_d;
    frame_t     frame_q;
    logic [2:0] idx_q;
    logic       last_byte;

    assign last_byte = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SEND;
            SEND:    state_d = TX_WAIT;
            TX_WAIT: if (tx_done) state_d = last_byte ? IDLE : SEND;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_start = (state_q == SEND);
        done     = (state_q == TX_WAIT) && tx_done && last_byte;
        state    = state_q;
    end

    // tx_data comes straight from the frame regs, so it stays put for the whole byte.
    assign tx_data = frame_byte(frame_q, idx_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_q <= '0;
            idx_q   <= '0;
        end else if (state_q == IDLE && start) begin
            frame_q <= frame_in;
            idx_q   <= '0;
        end else if (state_q == TX_WAIT && tx_done) begin
            idx_q <= last_byte ? 3'd0 : idx_q + 3'd1;
        end
    end

endmodule

// File: rtl/bip_uart_link.sv
// Control link: a start command clears and runs the BIP until halt or timeout,
// then the captured result frame is handed to frame_sender for transmission.
module bip_uart_link
    import bip_link_pkg::*;
#(
    parameter logic [7:0]  CMD_START  = CMD_START_DEF,
    parameter int          PC_W       = 11,
    parameter int          ACC_W      = 16,
    parameter logic [15:0] MAX_CYCLES = 16'hFFFE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    input  logic             tx_done,
    input  logic             bip_halt,
    input  logic [ACC_W-1:0] bip_acc,
    input  logic [PC_W-1:0]  bip_pc,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    output logic             bip_reset,
    output logic             bip_enable,
    output logic             busy,
    output state_e           dbg_state
);

    state_e      state_q;
    state_e      state_d;
    logic [15:0] cnt_q;
    logic        run_exit;
    logic        start_frame;
    logic        send_done;
    frame_t      frame_in;
    state_e      sender_state;

    // Halt and timeout may coincide; the status below lets halt win.
    assign run_exit = bip_halt || (cnt_q == MAX_CYCLES - 16'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // SEND here covers the whole frame transfer; the sender tracks SEND/TX_WAIT itself.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rx_done && rx_data == CMD_START) state_d = CLEAR;
            CLEAR:   state_d = RUN;
            RUN:     if (run_exit) state_d = SEND;
            SEND:    if (send_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bip_reset   = (state_q == CLEAR);
        bip_enable  = (state_q == RUN);
        busy        = (state_q != IDLE);
        start_frame = (state_q == RUN) && run_exit;
        dbg_state   = (state_q == SEND) ? sender_state : state_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (state_q == CLEAR) begin
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    always_comb begin
        frame_in.status = bip_halt ? STATUS_HALT : STATUS_TIMEOUT;
        frame_in.acc    = 16'(bip_acc);
        frame_in.pc     = 16'(bip_pc);
        frame_in.cyc    = cnt_q + 16'd1;
    end

    frame_sender u_sender (
        .clk      (clk),
        .reset    (reset),
        .start    (start_frame),
        .frame_in (frame_in),
        .tx_done  (tx_done),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .done     (send_done),
        .state    (sender_state)
    );

endmodule

// File: tb/tb_bip_uart_link.sv
// Bench for bip_uart_link: scripted/random runs against a timeline model of the link.
module tb_bip_uart_link;
    import bip_link_pkg::*;

    localparam int TB_MAX = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        tx_done = 1'b0;
    logic        bip_halt = 1'b0;
    logic [15:0] bip_acc = 16'h0000;
    logic [10:0] bip_pc = 11'h000;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        bip_reset;
    logic        bip_enable;
    logic        busy;
    state_e      dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic exp_reset = 1'b0;
    logic exp_enable = 1'b0;
    logic exp_busy = 1'b0;
    logic exp_start = 1'b0;
    logic exp_hold = 1'b0;
    bit   hold_off = 1'b1;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] held = 8'h00;
    int         en_cnt = 0;

    logic [7:0] t1_lit[7] = '{8'h00, 8'h12, 8'h34, 8'h00, 8'h07, 8'h00, 8'h05};
    logic [7:0] t5_lit[7] = '{8'h00, 8'hBE, 8'hEF, 8'h05, 8'hA5, 8'h00, 8'h06};

    always #5 clk = ~clk;

    bip_uart_link #(
        .CMD_START  (8'h53),
        .PC_W       (11),
        .ACC_W      (16),
        .MAX_CYCLES (16'(TB_MAX))
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .tx_done    (tx_done),
        .bip_halt   (bip_halt),
        .bip_acc    (bip_acc),
        .bip_pc     (bip_pc),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .bip_reset  (bip_reset),
        .bip_enable (bip_enable),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the expectations the driver publishes for the current cycle.
    always @(negedge clk) begin
        if (reset && !hold_off) begin
            check("bip_reset", 32'(bip_reset), 32'(exp_reset));
            check("bip_enable", 32'(bip_enable), 32'(exp_enable));
            check("busy", 32'(busy), 32'(exp_busy));
            check("tx_start", 32'(tx_start), 32'(exp_start));
            if (bip_enable) en_cnt++;
            if (tx_start) begin
                got_q.push_back(tx_data);
                if (exp_q.size() > 0) begin
                    held = exp_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(held));
                end
            end else if (exp_hold) begin
                check("tx_hold", 32'(tx_data), 32'(held));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic r, input logic e, input logic b, input logic s, input logic h);
        exp_reset  = r;
        exp_enable = e;
        exp_busy   = b;
        exp_start  = s;
        exp_hold   = h;
    endtask

    function automatic logic rnd(input bit en);
        return en && ($urandom_range(0, 2) == 0);
    endfunction

    task automatic do_abort();
        #2;
        hold_off = 1'b1;
        reset = 1'b0;
        #1;
        check("abort_tx_start", 32'(tx_start), 0);
        check("abort_tx_data", 32'(tx_data), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_enable", 32'(bip_enable), 0);
        check("abort_bip_reset", 32'(bip_reset), 0);
        exp_q.delete();
        set_exp(0, 0, 0, 0, 0);
        bip_halt = 1'b0;
        rx_done = 1'b0;
        tx_done = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        hold_off = 1'b0;
        tick();
    endtask

    // halt_n: 0 = halt already high entering RUN, 1..TB_MAX = halt in that RUN cycle, larger = never.
    task automatic run_cmd(input int halt_n, input logic [15:0] acc, input logic [10:0] pc,
                           input bit stray, input int abort_at);
        int          n;
        logic [7:0]  st;
        logic [15:0] pc16;
        logic [15:0] cyc16;
        n     = (halt_n == 0) ? 1 : ((halt_n < TB_MAX) ? halt_n : TB_MAX);
        st    = (halt_n <= TB_MAX) ? 8'h00 : 8'h01;
        pc16  = 16'(pc);
        cyc16 = 16'(n);
        en_cnt = 0;
        bip_acc = acc;
        bip_pc  = pc;
        rx_data = 8'h53;
        rx_done = 1'b1;
        tx_done = rnd(stray);
        tick();
        set_exp(1, 0, 1, 0, 0);
        rx_done  = rnd(stray);
        tx_done  = rnd(stray);
        bip_halt = (halt_n == 0);
        tick();
        for (int i = 1; i <= n; i++) begin
            set_exp(0, 1, 1, 0, 0);
            if (i == halt_n) bip_halt = 1'b1;
            rx_done = rnd(stray);
            tx_done = rnd(stray);
            if (i == n) begin
                exp_q.push_back(st);
                exp_q.push_back(acc[15:8]);
                exp_q.push_back(acc[7:0]);
                exp_q.push_back(pc16[15:8]);
                exp_q.push_back(pc16[7:0]);
                exp_q.push_back(cyc16[15:8]);
                exp_q.push_back(cyc16[7:0]);
            end
            tick();
        end
        bip_acc = 16'($urandom);
        bip_pc  = 11'($urandom);
        for (int b = 0; b < FRAME_LEN; b++) begin
            set_exp(0, 0, 1, 1, 0);
            rx_done = rnd(stray);
            tx_done = rnd(stray);
            tick();
            set_exp(0, 0, 1, 0, 1);
            rx_done = 1'b0;
            tx_done = 1'b0;
            if (b == abort_at) begin
                do_abort();
                return;
            end
            repeat ($urandom_range(0, 3)) begin
                rx_done = rnd(stray);
                tick();
            end
            tx_done = 1'b1;
            rx_done = stray;
            tick();
        end
        set_exp(0, 0, 0, 0, 0);
        rx_done = 1'b0;
        tx_done = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        set_exp(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_tx_start", 32'(tx_start), 0);
        check("reset_tx_data", 32'(tx_data), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_enable", 32'(bip_enable), 0);
        check("reset_bip_reset", 32'(bip_reset), 0);
        reset = 1'b1;
        hold_off = 1'b0;
        tick();
        tick();

        // 1: basic halt after 5 cycles
        got_q.delete();
        run_cmd(5, 16'h1234, 11'h007, 1'b0, -1);
        check("t1_enable_cycles", 32'(en_cnt), 5);
        check("t1_len", 32'(got_q.size()), 7);
        if (got_q.size() == 7)
            for (int i = 0; i < 7; i++) check("t1_byte", 32'(got_q[i]), 32'(t1_lit[i]));
        tick();

        // 2: non-command bytes, halt and tx_done in IDLE are ignored
        for (int i = 0; i < 8; i++) begin
            do rx_data = 8'($urandom); while (rx_data == 8'h53);
            rx_done  = 1'($urandom);
            bip_halt = 1'($urandom);
            tx_done  = 1'($urandom);
            tick();
        end
        rx_done = 1'b0;
        tx_done = 1'b0;
        tick();
        check("t2_busy", 32'(busy), 0);

        // 3: timeout
        got_q.delete();
        run_cmd(100, 16'hA5A5, 11'h123, 1'b0, -1);
        check("t3_enable_cycles", 32'(en_cnt), 8);
        check("t3_len", 32'(got_q.size()), 7);
        if (got_q.size() == 7) begin
            check("t3_status", 32'(got_q[0]), 32'h01);
            check("t3_cyc_hi", 32'(got_q[5]), 32'h00);
            check("t3_cyc_lo", 32'(got_q[6]), 32'h08);
        end

        // 4: stray commands during RUN and TX_WAIT
        got_q.delete();
        run_cmd(3, 16'($urandom), 11'($urandom), 1'b1, -1);
        repeat (3) tick();
        check("t4_len", 32'(got_q.size()), 7);
        check("t4_enable_cycles", 32'(en_cnt), 3);

        // 5: reset mid-frame, then a complete fresh frame
        run_cmd(4, 16'h7777, 11'h321, 1'b0, 4);
        got_q.delete();
        run_cmd(6, 16'hBEEF, 11'h5A5, 1'b0, -1);
        check("t5_len", 32'(got_q.size()), 7);
        if (got_q.size() == 7)
            for (int i = 0; i < 7; i++) check("t5_byte", 32'(got_q[i]), 32'(t5_lit[i]));

        // 6: halt already high on RUN entry, rx/tx on the same edge
        got_q.delete();
        run_cmd(0, 16'h00FF, 11'h7FF, 1'b1, -1);
        tick();
        check("t6_enable_cycles", 32'(en_cnt), 1);
        if (got_q.size() == 7) begin
            check("t6_status", 32'(got_q[0]), 32'h00);
            check("t6_pc_hi", 32'(got_q[3]), 32'h07);
            check("t6_pc_lo", 32'(got_q[4]), 32'hFF);
            check("t6_cyc_lo", 32'(got_q[6]), 32'h01);
        end else begin
            check("t6_len", 32'(got_q.size()), 7);
        end

        // halt and timeout on the same edge: halt status wins
        got_q.delete();
        run_cmd(TB_MAX, 16'h0001, 11'h002, 1'b0, -1);
        check("tmax_enable_cycles", 32'(en_cnt), TB_MAX);
        if (got_q.size() == 7) begin
            check("tmax_status", 32'(got_q[0]), 32'h00);
            check("tmax_cyc_lo", 32'(got_q[6]), 32'(TB_MAX));
        end else begin
            check("tmax_len", 32'(got_q.size()), 7);
        end

        // random runs
        for (int r = 0; r < 12; r++) begin
            int hn;
            hn = $urandom_range(0, TB_MAX + 2);
            got_q.delete();
            run_cmd(hn, 16'($urandom), 11'($urandom), 1'($urandom), -1);
            check("rand_len", 32'(got_q.size()), 7);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        check("exp_q_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
